// File: rtl/decode_pipe.sv
// ---------------------------------------------------------------------------
// decode_pipe
//   Registered, handshaked instruction-decode stage of the SIMT core. Accepts
//   one instruction per cycle from fetch, decodes it into a control bundle,
//   applies per-lane predication and sequences the SYNC barrier wait and the
//   EXIT halt. Branch resolution lives in execute; this stage only emits
//   class flags.
//
//   Optional build macro: DECODE_PERF_EN adds three saturating 16-bit
//   performance counters (perf_issued, perf_masked, perf_sync_stall).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         fetch handshake
//   instr                       instruction; op=[31:29], pred=[28], funct4=[13:10]
//   active_mask, pred_mask      live lanes, per-lane predicate register
//   flush                       execute redirect, kills held and incoming instr
//   sync_done                   barrier release pulse
//   out_valid / out_ready       execute handshake
//   alu_ctrl .. illegal         decoded control bundle
//   thread_mask                 lanes that execute this bundle
//   sync_req, halted            barrier arrival / EXIT retired
//
// Encoding
//   op:  000 R-type, 001 I-type, 010 M-type, 011 C-type, others illegal
//   ALU: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SLT, 5 SEQ, 6 MIN, 7 ABS
//        R/I-type funct4 values equal the ALU code they select.
//
// States
//   state        | meaning
//   ST_RUN       | normal issue
//   ST_SYNC_WAIT | SYNC issued, waiting for sync_done; no accepts
//   ST_HALT      | EXIT issued; stays here until reset
// ---------------------------------------------------------------------------
module decode_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_THREADS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  instr,
    input  logic [NUM_THREADS-1:0] active_mask,
    input  logic [NUM_THREADS-1:0] pred_mask,
    input  logic                   flush,
    input  logic                   sync_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             alu_ctrl,
    output logic                   alu_src,
    output logic [2:0]             imm_src,
    output logic                   reg_write,
    output logic                   mem_write,
    output logic                   result_src,
    output logic                   wd3_src,
    output logic                   is_jump,
    output logic                   is_branch,
    output logic                   is_call,
    output logic                   is_ret,
    output logic                   is_exit,
    output logic                   illegal,
    output logic [NUM_THREADS-1:0] thread_mask,
    output logic                   sync_req,
    output logic                   halted
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0]            perf_issued,
    output logic [15:0]            perf_masked,
    output logic [15:0]            perf_sync_stall
`endif
);

    localparam logic [2:0] OP_R = 3'd0;
    localparam logic [2:0] OP_I = 3'd1;
    localparam logic [2:0] OP_M = 3'd2;
    localparam logic [2:0] OP_C = 3'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_DIV = 4'd3;
    localparam logic [3:0] ALU_SEQ = 4'd5;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SYNC_WAIT = 2'd1,
        ST_HALT      = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]             alu_ctrl;
        logic                   alu_src;
        logic [2:0]             imm_src;
        logic                   reg_write;
        logic                   mem_write;
        logic                   result_src;
        logic                   wd3_src;
        logic                   is_jump;
        logic                   is_branch;
        logic                   is_call;
        logic                   is_ret;
        logic                   is_exit;
        logic                   illegal;
        logic [NUM_THREADS-1:0] thread_mask;
    } bundle_t;

    state_t  state_q, state_d;
    bundle_t bun_q, bun_d;
    logic    out_valid_q, out_valid_d;
    logic    accept;
    logic    sync_op, exit_op;

    logic [31:0] ins;
    logic [2:0]  op;
    logic [3:0]  f4;
    logic [2:0]  f3;
    logic        unused_ins;

    assign ins = instr[31:0];
    assign op  = ins[31:29];
    assign f4  = ins[13:10];
    assign f3  = ins[12:10];
    assign unused_ins = ^{ins[27:14], ins[9:0]};

    generate
        if (DATA_WIDTH > 32) begin : g_wide
            logic unused_hi;
            assign unused_hi = ^instr[DATA_WIDTH-1:32];
        end
    endgenerate

    // Decode
    always_comb begin
        bun_d   = '0;
        sync_op = 1'b0;
        exit_op = 1'b0;
        case (op)
            OP_R: begin
                bun_d.reg_write = 1'b1;
                bun_d.alu_ctrl  = f4[3] ? ALU_ADD : f4;
            end
            OP_I: begin
                bun_d.reg_write = 1'b1;
                bun_d.alu_src   = 1'b1;
                bun_d.alu_ctrl  = (f4 == ALU_MUL || f4 == ALU_DIV) ? f4 : ALU_ADD;
            end
            OP_M: begin
                case (f4)
                    4'd0: begin
                        bun_d.reg_write  = 1'b1;
                        bun_d.alu_src    = 1'b1;
                        bun_d.result_src = 1'b1;
                        bun_d.imm_src    = 3'b001;
                    end
                    4'd1: begin
                        bun_d.mem_write = 1'b1;
                        bun_d.imm_src   = 3'b010;
                    end
                    default: bun_d.illegal = 1'b1;
                endcase
            end
            OP_C: begin
                case (f3)
                    3'd0: begin
                        bun_d.is_jump   = 1'b1;
                        bun_d.reg_write = 1'b1;
                        bun_d.wd3_src   = 1'b1;
                        bun_d.alu_src   = 1'b1;
                        bun_d.imm_src   = 3'b011;
                    end
                    3'd1: begin
                        bun_d.is_branch = 1'b1;
                        bun_d.alu_ctrl  = ALU_SEQ;
                        bun_d.imm_src   = 3'b011;
                    end
                    3'd2: begin
                        bun_d.is_call   = 1'b1;
                        bun_d.reg_write = 1'b1;
                        bun_d.wd3_src   = 1'b1;
                        bun_d.imm_src   = 3'b100;
                    end
                    3'd3: begin
                        bun_d.is_ret  = 1'b1;
                        bun_d.alu_src = 1'b1;
                    end
                    3'd6: sync_op = 1'b1;
                    3'd7: begin
                        exit_op       = 1'b1;
                        bun_d.is_exit = 1'b1;
                    end
                    default: bun_d.illegal = 1'b1;
                endcase
            end
            default: bun_d.illegal = 1'b1;
        endcase

        bun_d.thread_mask = ins[28] ? (active_mask & pred_mask) : active_mask;
        // A bundle with no executing lane must not write anything.
        if (bun_d.thread_mask == '0) begin
            bun_d.reg_write = 1'b0;
            bun_d.mem_write = 1'b0;
        end
    end

    // Handshake
    assign in_ready = (state_q == ST_RUN) & ~flush & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (accept)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && sync_op)
                    state_d = ST_SYNC_WAIT;
                else if (accept && exit_op)
                    state_d = ST_HALT;
            end
            ST_SYNC_WAIT: begin
                if (sync_done || flush)
                    state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            bun_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (accept)
                bun_q <= bun_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_ctrl    = bun_q.alu_ctrl;
    assign alu_src     = bun_q.alu_src;
    assign imm_src     = bun_q.imm_src;
    assign reg_write   = bun_q.reg_write;
    assign mem_write   = bun_q.mem_write;
    assign result_src  = bun_q.result_src;
    assign wd3_src     = bun_q.wd3_src;
    assign is_jump     = bun_q.is_jump;
    assign is_branch   = bun_q.is_branch;
    assign is_call     = bun_q.is_call;
    assign is_ret      = bun_q.is_ret;
    assign is_exit     = bun_q.is_exit;
    assign illegal     = bun_q.illegal;
    assign thread_mask = bun_q.thread_mask;
    assign sync_req    = (state_q == ST_SYNC_WAIT);
    assign halted      = (state_q == ST_HALT);

`ifdef DECODE_PERF_EN
    logic [15:0] perf_issued_q, perf_masked_q, perf_sync_stall_q;
    logic        masked_pred;

    assign masked_pred = accept & ins[28] & (bun_d.thread_mask == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q     <= '0;
            perf_masked_q     <= '0;
            perf_sync_stall_q <= '0;
        end else begin
            if (accept && perf_issued_q != 16'hFFFF)
                perf_issued_q <= perf_issued_q + 16'd1;
            if (masked_pred && perf_masked_q != 16'hFFFF)
                perf_masked_q <= perf_masked_q + 16'd1;
            if (state_q == ST_SYNC_WAIT && perf_sync_stall_q != 16'hFFFF)
                perf_sync_stall_q <= perf_sync_stall_q + 16'd1;
        end
    end

    assign perf_issued     = perf_issued_q;
    assign perf_masked     = perf_masked_q;
    assign perf_sync_stall = perf_sync_stall_q;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a transaction-level reference model of decode_pipe.
// ---------------------------------------------------------------------------
module tb_decode_pipe;

    localparam int NT = 8;

    localparam int K_R    = 0;
    localparam int K_I    = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_JMP  = 4;
    localparam int K_BR   = 5;
    localparam int K_CALL = 6;
    localparam int K_RET  = 7;
    localparam int K_SYNC = 8;
    localparam int K_EXIT = 9;
    localparam int K_BAD  = 10;

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [31:0]   instr;
    logic [NT-1:0] active_mask, pred_mask;
    logic          flush, sync_done;
    logic          out_valid, out_ready;
    logic [3:0]    alu_ctrl;
    logic          alu_src;
    logic [2:0]    imm_src;
    logic          reg_write, mem_write, result_src, wd3_src;
    logic          is_jump, is_branch, is_call, is_ret, is_exit, illegal;
    logic [NT-1:0] thread_mask;
    logic          sync_req, halted;
`ifdef DECODE_PERF_EN
    logic [15:0]   perf_issued, perf_masked, perf_sync_stall;
`endif

    decode_pipe #(.DATA_WIDTH(32), .NUM_THREADS(NT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .active_mask(active_mask), .pred_mask(pred_mask),
        .flush(flush), .sync_done(sync_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm_src(imm_src),
        .reg_write(reg_write), .mem_write(mem_write),
        .result_src(result_src), .wd3_src(wd3_src),
        .is_jump(is_jump), .is_branch(is_branch), .is_call(is_call),
        .is_ret(is_ret), .is_exit(is_exit), .illegal(illegal),
        .thread_mask(thread_mask), .sync_req(sync_req), .halted(halted)
`ifdef DECODE_PERF_EN
        , .perf_issued(perf_issued), .perf_masked(perf_masked),
        .perf_sync_stall(perf_sync_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_st;      // 0 run, 1 waiting for barrier, 2 halted
    logic        m_ov;
    logic [25:0] m_exp;

    function automatic logic [31:0] mk(input logic [2:0] op, input logic p, input logic [3:0] f);
        mk = {op, p, 14'd0, f, 10'd0};
    endfunction

    function automatic int ref_kind(input logic [31:0] i);
        int f4, f3;
        f4 = int'(i[13:10]);
        f3 = f4 % 8;
        case (int'(i[31:29]))
            0: return K_R;
            1: return K_I;
            2: return (f4 == 0) ? K_LD : (f4 == 1) ? K_ST : K_BAD;
            3: begin
                case (f3)
                    0: return K_JMP;
                    1: return K_BR;
                    2: return K_CALL;
                    3: return K_RET;
                    6: return K_SYNC;
                    7: return K_EXIT;
                    default: return K_BAD;
                endcase
            end
            default: return K_BAD;
        endcase
    endfunction

    // Bundle layout: {alu[3:0], asrc, imm[2:0], rw, mw, rs, wd, j, b, c, r, e, ill, mask[7:0]}
    function automatic logic [25:0] ref_decode(input logic [31:0] i, input logic [NT-1:0] act,
                                               input logic [NT-1:0] prd);
        int k, f4, alu, imm;
        logic asrc, rw, mw, rs, wd, j, b, c, r, e, ill;
        logic [NT-1:0] m;
        k = ref_kind(i);
        f4 = int'(i[13:10]);
        alu = 0; imm = 0;
        {asrc, rw, mw, rs, wd, j, b, c, r, e, ill} = '0;
        case (k)
            K_R:    begin rw = 1; alu = (f4 < 8) ? f4 : 0; end
            K_I:    begin rw = 1; asrc = 1; alu = (f4 == 2 || f4 == 3) ? f4 : 0; end
            K_LD:   begin rw = 1; asrc = 1; rs = 1; imm = 1; end
            K_ST:   begin mw = 1; imm = 2; end
            K_JMP:  begin j = 1; rw = 1; wd = 1; asrc = 1; imm = 3; end
            K_BR:   begin b = 1; alu = 5; imm = 3; end
            K_CALL: begin c = 1; rw = 1; wd = 1; imm = 4; end
            K_RET:  begin r = 1; asrc = 1; end
            K_EXIT: e = 1;
            K_BAD:  ill = 1;
            default: ;
        endcase
        m = i[28] ? (act & prd) : act;
        if (m == 0) begin rw = 0; mw = 0; end
        return {alu[3:0], asrc, imm[2:0], rw, mw, rs, wd, j, b, c, r, e, ill, m};
    endfunction

    function automatic logic [25:0] got_bundle();
        return {alu_ctrl, alu_src, imm_src, reg_write, mem_write, result_src, wd3_src,
                is_jump, is_branch, is_call, is_ret, is_exit, illegal, thread_mask};
    endfunction

    task automatic check_outs();
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("sync_req", {31'd0, sync_req}, {31'd0, m_st == 1});
        check("halted", {31'd0, halted}, {31'd0, m_st == 2});
        if (m_ov)
            check("bundle", {6'd0, got_bundle()}, {6'd0, m_exp});
    endtask

    // One clock cycle: drive at the falling edge, check in_ready, advance the
    // model, then check registered outputs at the next falling edge.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [NT-1:0] act,
                       input logic [NT-1:0] prd, input logic fl, input logic sd, input logic ordy);
        logic rdy, acc;
        in_valid = iv; instr = ins; active_mask = act; pred_mask = prd;
        flush = fl; sync_done = sd; out_ready = ordy;
        #1;
        rdy = (m_st == 0) && !fl && (!m_ov || ordy);
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        acc = iv && rdy;
        if (fl) m_ov = 1'b0;
        else if (acc) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
        if (acc) m_exp = ref_decode(ins, act, prd);
        if (m_st == 0 && acc && ref_kind(ins) == K_SYNC) m_st = 1;
        else if (m_st == 0 && acc && ref_kind(ins) == K_EXIT) m_st = 2;
        else if (m_st == 1 && (sd || fl)) m_st = 0;
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset(input string tag);
        in_valid = 1'b0; flush = 1'b0; sync_done = 1'b0; out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_bundle"}, {6'd0, got_bundle()}, 32'd0);
        check({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_sreq"}, {31'd0, sync_req}, 32'd0);
        check({tag, "_halt"}, {31'd0, halted}, 32'd0);
        check({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
        m_st = 0; m_ov = 1'b0; m_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  op;
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; active_mask = '0; pred_mask = '0;
        flush = 1'b0; sync_done = 1'b0; out_ready = 1'b1;
        m_st = 0; m_ov = 1'b0; m_exp = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs();
        check("rst_bundle", {6'd0, got_bundle()}, 32'd0);

        // Stream ADD, MUL, load, store at full rate
        cyc(1, mk(3'd0, 0, 4'd0), 8'hFF, 8'h00, 0, 0, 1);
        check("add_alu", {28'd0, alu_ctrl}, 32'd0);
        cyc(1, mk(3'd0, 0, 4'd2), 8'hFF, 8'h00, 0, 0, 1);
        check("mul_alu", {28'd0, alu_ctrl}, 32'd2);
        cyc(1, mk(3'd2, 0, 4'd0), 8'hFF, 8'h00, 0, 0, 1);
        check("ld_rsrc", {31'd0, result_src}, 32'd1);
        check("ld_imm", {29'd0, imm_src}, 32'd1);
        cyc(1, mk(3'd2, 0, 4'd1), 8'hFF, 8'h00, 0, 0, 1);
        check("st_mw", {31'd0, mem_write}, 32'd1);
        check("st_rw", {31'd0, reg_write}, 32'd0);
        idle(1);

        // Backpressure with a held bundle
        cyc(1, mk(3'd1, 0, 4'd2), 8'hFF, 8'h00, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, mk(3'd0, 0, 4'd1), 8'hFF, 8'h00, 0, 0, 0);
        check("held_alu", {28'd0, alu_ctrl}, 32'd2);
        cyc(1, mk(3'd0, 0, 4'd1), 8'hFF, 8'h00, 0, 0, 1);
        check("rel_sub", {28'd0, alu_ctrl}, 32'd1);
        idle(1);

        // Predication
        cyc(1, mk(3'd0, 1, 4'd0), 8'hF0, 8'h3C, 0, 0, 1);
        check("pred_and", {24'd0, thread_mask}, 32'h30);
        cyc(1, mk(3'd0, 1, 4'd0), 8'hF0, 8'h0F, 0, 0, 1);
        check("pred_zero", {24'd0, thread_mask}, 32'h00);
        check("pred_zero_rw", {31'd0, reg_write}, 32'd0);
        cyc(1, mk(3'd0, 0, 4'd0), 8'hF0, 8'h0F, 0, 0, 1);
        check("pred_off", {24'd0, thread_mask}, 32'hF0);

        // SYNC barrier, then released by sync_done
        cyc(1, mk(3'd3, 0, 4'd6), 8'hFF, 8'h00, 0, 0, 1);
        for (int k = 0; k < 5; k++) cyc(1, mk(3'd0, 0, 4'd4), 8'hFF, 8'h00, 0, 0, 1);
        check("sync_req_hi", {31'd0, sync_req}, 32'd1);
        cyc(1, mk(3'd0, 0, 4'd4), 8'hFF, 8'h00, 0, 1, 1);
        cyc(1, mk(3'd0, 0, 4'd4), 8'hFF, 8'h00, 0, 0, 1);
        check("post_sync_slt", {28'd0, alu_ctrl}, 32'd4);

        // SYNC released by flush
        cyc(1, mk(3'd3, 0, 4'd6), 8'hFF, 8'h00, 0, 0, 1);
        idle(2);
        cyc(0, 32'd0, 8'hFF, 8'h00, 1, 0, 1);
        idle(1);

        // Flush kills the held bundle and the incoming instruction
        cyc(1, mk(3'd0, 0, 4'd6), 8'hFF, 8'h00, 0, 0, 0);
        cyc(1, mk(3'd0, 0, 4'd7), 8'hFF, 8'h00, 1, 0, 1);
        check("flush_ov", {31'd0, out_valid}, 32'd0);
        cyc(1, mk(3'd3, 0, 4'd4), 8'hFF, 8'h00, 0, 0, 1);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_we", {30'd0, reg_write, mem_write}, 32'd0);
        cyc(1, mk(3'd6, 0, 4'd0), 8'hFF, 8'h00, 0, 0, 1);
        idle(1);

        // Reset during SYNC_WAIT with a held bundle
        cyc(1, mk(3'd3, 0, 4'd6), 8'hFF, 8'h00, 0, 0, 0);
        cyc(0, 32'd0, 8'hFF, 8'h00, 0, 0, 0);
        do_reset("rst_wait");

        // Randomized traffic (EXIT excluded so the run can continue)
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 3));
            r[31:29] = op;
            if (op == 3'd3 && r[12:10] == 3'd7) r[12:10] = 3'd0;
            cyc($urandom_range(0, 3) != 0, r,
                ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                8'($urandom),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0);
        end
        cyc(0, 32'd0, 8'hFF, 8'h00, 1, 0, 1);
        idle(1);

        // EXIT, then flush must not leave HALT
        cyc(1, mk(3'd3, 0, 4'd7), 8'hFF, 8'h00, 0, 0, 1);
        check("exit_flag", {31'd0, is_exit}, 32'd1);
        for (int k = 0; k < 20; k++)
            cyc(1, mk(3'd0, 0, 4'd0), 8'hFF, 8'h00, k[0], k[1], 1);
        check("halt_stays", {31'd0, halted}, 32'd1);
        do_reset("rst_halt");
        cyc(1, mk(3'd0, 0, 4'd3), 8'hFF, 8'h00, 0, 0, 1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Registered, handshaked instruction-decode stage for the SIMT core; the pipelined, multi-thread successor to the combinational control decoder.
- Sits between fetch and execute. Decodes one instruction per cycle into control fields, applies per-thread predication to produce a lane mask, and owns the SYNC barrier wait and EXIT halt sequencing.
- Branch resolution moves to execute: this block emits flags, not pc_src.

Parameters:
- DATA_WIDTH, 32, instruction width; must be >= 32.
- NUM_THREADS, 8, lanes per warp; width of all mask ports; 1..32.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instr
- in_ready  out  1  stage can accept
- instr  in  DATA_WIDTH  instruction; op=[31:29], pred=[28], funct4=[13:10], funct3=[12:10]
- active_mask  in  NUM_THREADS  currently live lanes
- pred_mask  in  NUM_THREADS  per-lane predicate register
- flush  in  1  execute redirect; kills held and incoming instruction
- sync_done  in  1  barrier release pulse
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- alu_ctrl  out  4  shared ALU macro codes
- alu_src  out  1  1 = immediate operand
- imm_src  out  3  000 I, 001 load, 010 store, 011 branch/jump, 100 call
- reg_write, mem_write, result_src, wd3_src  out  1 each  as in legacy decode
- is_jump, is_branch, is_call, is_ret, is_exit, illegal  out  1 each  class flags
- thread_mask  out  NUM_THREADS  lanes that execute
- sync_req  out  1  barrier arrival, held while waiting
- halted  out  1  EXIT retired into stage

Behaviour:
- Reset values: every output register is 0, state=RUN, and in_ready=1.
- in_ready = (state==RUN) & !flush & (!out_valid | out_ready), combinational.
- Accept on in_valid & in_ready. The bundle is registered and appears next cycle, so latency is 1.
- Bundle registers hold stable while out_valid & !out_ready.
- out_valid clears on out_ready unless a new accept occurs in the same cycle. Back-to-back issue sustains 1 instruction per cycle.
- Decode tables:
  - R-type: funct4 selects ADD/SUB/MUL/DIV/SLT/SEQ/MIN/ABS; any other value gives ADD. reg_write=1.
  - I-type: ADD/MUL/DIV, else ADD; alu_src=1.
  - M-type funct4 0 = load: reg_write, alu_src, result_src, imm 001.
  - M-type funct4 1 = store: mem_write, imm 010.
  - C-type funct3 0 = jump: reg_write, wd3_src, alu_src, imm 011.
  - C-type funct3 1 = branch: alu_ctrl SEQ, imm 011.
  - C-type funct3 2 = call: reg_write, wd3_src, imm 100.
  - C-type funct3 3 = ret: alu_src, ADD.
  - C-type funct3 6 = SYNC; funct3 7 = EXIT.
- Illegal: unknown M funct4, unknown C funct3, or unknown op. Set illegal=1 with all write enables 0; the bundle still issues.
- Predication: if instr[28], thread_mask = active_mask & pred_mask; else thread_mask = active_mask.
  - If the result is 0, force reg_write=mem_write=0; is_* flags are kept.
- FSM RUN / SYNC_WAIT / HALT:
  - RUN -> SYNC_WAIT when SYNC is accepted. The SYNC bundle issues as a no-op; sync_req=1 from the next cycle.
  - SYNC_WAIT -> RUN on sync_done, and sync_req falls the same edge. sync_done in RUN is ignored.
  - SYNC_WAIT -> RUN on flush, and sync_req drops.
  - RUN -> HALT when EXIT is accepted: is_exit bundle issues, halted=1 next cycle. HALT is left only by reset; flush has no effect.
- Flush: out_valid cleared next edge (flush wins over out_ready). An instruction presented in the flush cycle is not accepted.
- rst_n low at any time: immediate return to reset values, including mid-SYNC_WAIT and a held bundle.

Optional Feature:
- DECODE_PERF_EN defined: adds outputs perf_issued, perf_masked and perf_sync_stall, each 16 bits, saturating at 0xFFFF, reset to 0.
  - perf_issued counts accepts.
  - perf_masked counts predicated bundles whose mask is zero.
  - perf_sync_stall counts cycles in SYNC_WAIT.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then stream ADD, MUL, load, store with out_ready=1 -> one bundle per cycle, latency 1. Load gives result_src=1, imm 001; store gives mem_write=1, reg_write=0.
- out_ready=0 for 3 cycles with a bundle held -> in_ready=0 and the bundle is stable. Release -> the next instr issues the following cycle.
- Predication with NUM_THREADS=8, active=0xF0, pred=0x3C:
  - pred bit 1 -> mask 0x30.
  - pred=0x0F with pred bit 1 -> mask 0, reg_write=0.
  - pred bit 0 -> mask 0xF0.
- SYNC accepted -> sync_req=1 and in_ready=0 for 5 cycles. sync_done pulse -> RUN next cycle; the next instr is accepted.
- EXIT -> halted=1 and in_ready stays 0 for 20 cycles despite flush. rst_n pulse -> all zero, in_ready=1.
- Flush with a held bundle and a new in_valid -> out_valid=0 next cycle and the new instr is not consumed. C-type funct3=4 -> illegal=1, all write enables 0.
